// File: rtl/dserve_queue.sv
// dserve_queue: in-order request queue between the CPU data port and the dcache.
// Requests are buffered in a circular FIFO; the head entry is held on ufp_*
// until the dcache responds, and completions return to the CPU in order.
// Optional feature: define DSERVE_BYPASS_EN to let a request reach the dcache
// in the same cycle it is presented when the queue is empty.
module dserve_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        cpu_ufp_addr,
    input  logic [DATA_W/8-1:0]      cpu_ufp_rmask,
    input  logic [DATA_W/8-1:0]      cpu_ufp_wmask,
    input  logic [DATA_W-1:0]        cpu_ufp_wdata,
    output logic                     cpu_ready,
    output logic [ADDR_W-1:0]        ufp_addr,
    output logic [DATA_W/8-1:0]      ufp_rmask,
    output logic [DATA_W/8-1:0]      ufp_wmask,
    output logic [DATA_W-1:0]        ufp_wdata,
    input  logic                     ufp_resp,
    input  logic [DATA_W-1:0]        ufp_rdata,
    output logic                     cpu_resp,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int MW = DATA_W / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic [MW-1:0]     rmask_mem [DEPTH];
    logic [MW-1:0]     wmask_mem [DEPTH];
    logic [DATA_W-1:0] wdata_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic req_valid;
    logic not_empty;
    logic bypass;
    logic bypass_done;
    logic push;
    logic pop;

    assign req_valid = |(cpu_ufp_rmask | cpu_ufp_wmask);
    assign not_empty = (count != '0);

    // Ready depends only on registered occupancy, so a same-cycle pop never raises it.
    assign cpu_ready = (count < CW'(DEPTH));

`ifdef DSERVE_BYPASS_EN
    // An empty queue forwards the live CPU request straight to the dcache.
    assign bypass = !rst && !not_empty && req_valid;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed request answered in the same cycle never needs a slot.
    assign bypass_done = bypass && ufp_resp;
    assign pop         = ufp_resp && not_empty;
    assign push        = req_valid && cpu_ready && !bypass_done;

    // Write accepted requests at the tail; storage is cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i]  <= '0;
                rmask_mem[i] <= '0;
                wmask_mem[i] <= '0;
                wdata_mem[i] <= '0;
            end
        end else if (push) begin
            addr_mem[tail]  <= cpu_ufp_addr;
            rmask_mem[tail] <= cpu_ufp_rmask;
            wmask_mem[tail] <= cpu_ufp_wmask;
            wdata_mem[tail] <= cpu_ufp_wdata;
        end
    end

    // Advance head/tail (wrapping modulo DEPTH) and track occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Present the head entry, the bypassed request, or idle zeros to the dcache.
    always_comb begin
        ufp_addr  = '0;
        ufp_rmask = '0;
        ufp_wmask = '0;
        ufp_wdata = '0;
        if (not_empty) begin
            ufp_addr  = addr_mem[head];
            ufp_rmask = rmask_mem[head];
            ufp_wmask = wmask_mem[head];
            ufp_wdata = wdata_mem[head];
        end else if (bypass) begin
            ufp_addr  = cpu_ufp_addr;
            ufp_rmask = cpu_ufp_rmask;
            ufp_wmask = cpu_ufp_wmask;
            ufp_wdata = cpu_ufp_wdata;
        end
    end

    // Return completions only for requests actually outstanding.
    always_comb begin
        cpu_resp  = ufp_resp && (not_empty || bypass);
        cpu_rdata = '0;
        if (cpu_resp) begin
            cpu_rdata = ufp_rdata;
        end
    end

endmodule

// File: tb/tb_dserve_queue.sv
// Bench for dserve_queue: a queue-based reference model predicts every output
// each cycle; directed cycles add hand-computed literal expectations.
// Define DSERVE_BYPASS_EN for both bench and design to cover the bypass build.
module tb_dserve_queue;

    localparam int DEPTH = 4;

`ifdef DSERVE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] wd;
    } req_t;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_ufp_addr;
    logic [3:0]  cpu_ufp_rmask;
    logic [3:0]  cpu_ufp_wmask;
    logic [31:0] cpu_ufp_wdata;
    logic        cpu_ready;
    logic [31:0] ufp_addr;
    logic [3:0]  ufp_rmask;
    logic [3:0]  ufp_wmask;
    logic [31:0] ufp_wdata;
    logic        ufp_resp;
    logic [31:0] ufp_rdata;
    logic        cpu_resp;
    logic [31:0] cpu_rdata;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    req_t mq[$];

    int          lit_n = 0;
    string       lit_name [4];
    int          lit_sel  [4];
    logic [63:0] lit_exp  [4];

    dserve_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .cpu_ufp_addr(cpu_ufp_addr),
        .cpu_ufp_rmask(cpu_ufp_rmask),
        .cpu_ufp_wmask(cpu_ufp_wmask),
        .cpu_ufp_wdata(cpu_ufp_wdata),
        .cpu_ready(cpu_ready),
        .ufp_addr(ufp_addr),
        .ufp_rmask(ufp_rmask),
        .ufp_wmask(ufp_wmask),
        .ufp_wdata(ufp_wdata),
        .ufp_resp(ufp_resp),
        .ufp_rdata(ufp_rdata),
        .cpu_resp(cpu_resp),
        .cpu_rdata(cpu_rdata),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: list of outstanding requests, oldest first.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            int   sz;
            bit   valid;
            bit   byp;
            req_t cur;
            sz    = mq.size();
            valid = (cpu_ufp_rmask | cpu_ufp_wmask) != 4'h0;
            byp   = BYP && (sz == 0) && valid;
            cur   = '{cpu_ufp_addr, cpu_ufp_rmask, cpu_ufp_wmask, cpu_ufp_wdata};
            if (ufp_resp && sz > 0) void'(mq.pop_front());
            if (valid && sz < DEPTH && !(byp && ufp_resp)) mq.push_back(cur);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] act_of(input int sel);
        case (sel)
            0:       return 64'(ufp_addr);
            1:       return 64'(cpu_resp);
            2:       return 64'(cpu_rdata);
            3:       return 64'(count);
            4:       return 64'(cpu_ready);
            5:       return 64'(ufp_rmask);
            default: return 64'(ufp_wmask);
        endcase
    endfunction

    // Compare every output against the model, then any literal expectations.
    always @(negedge clk) begin
        if (chk_on) begin
            int   sz;
            bit   valid;
            bit   byp;
            bit   eresp;
            req_t cur;
            req_t eufp;
            sz    = mq.size();
            valid = (cpu_ufp_rmask | cpu_ufp_wmask) != 4'h0;
            byp   = BYP && !rst && (sz == 0) && valid;
            cur   = '{cpu_ufp_addr, cpu_ufp_rmask, cpu_ufp_wmask, cpu_ufp_wdata};
            eufp  = (sz > 0) ? mq[0] : (byp ? cur : '0);
            eresp = ufp_resp && (sz > 0 || byp);
            chk("count",     64'(count),     64'(sz));
            chk("cpu_ready", 64'(cpu_ready), 64'(sz < DEPTH));
            chk("ufp_addr",  64'(ufp_addr),  64'(eufp.addr));
            chk("ufp_rmask", 64'(ufp_rmask), 64'(eufp.rm));
            chk("ufp_wmask", 64'(ufp_wmask), 64'(eufp.wm));
            chk("ufp_wdata", 64'(ufp_wdata), 64'(eufp.wd));
            chk("cpu_resp",  64'(cpu_resp),  64'(eresp));
            chk("cpu_rdata", 64'(cpu_rdata), eresp ? 64'(ufp_rdata) : 64'h0);
            for (int i = 0; i < lit_n; i++) begin
                chk(lit_name[i], act_of(lit_sel[i]), lit_exp[i]);
            end
        end
    end

    task automatic cyc(input logic r, input logic [31:0] a, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd,
                       input logic resp, input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst           = r;
        cpu_ufp_addr  = a;
        cpu_ufp_rmask = rm;
        cpu_ufp_wmask = wm;
        cpu_ufp_wdata = wd;
        ufp_resp      = resp;
        ufp_rdata     = rd;
        lit_n         = 0;
        chk_on        = 1'b1;
    endtask

    task automatic idle(input logic resp, input logic [31:0] rd);
        cyc(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, resp, rd);
    endtask

    task automatic lit(input string n, input int sel, input logic [63:0] e);
        lit_name[lit_n] = n;
        lit_sel[lit_n]  = sel;
        lit_exp[lit_n]  = e;
        lit_n++;
    endtask

    initial begin
        rst = 1'b0;
        cpu_ufp_addr = '0; cpu_ufp_rmask = '0; cpu_ufp_wmask = '0; cpu_ufp_wdata = '0;
        ufp_resp = 1'b0; ufp_rdata = '0;

        // Reset with a stray response present: idle outputs.
        cyc(1'b1, 32'h0, 4'h0, 4'h0, 32'h0, 1'b1, 32'h5555);
        lit("rst_ready", 4, 64'h1); lit("rst_count", 3, 64'h0);
        lit("rst_resp", 1, 64'h0);  lit("rst_addr", 0, 64'h0);
        cyc(1'b1, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        idle(1'b0, 32'h0);

        // Single read.
        cyc(1'b0, 32'h100, 4'hF, 4'h0, 32'h0, 1'b0, 32'h0);
        lit("rd_rmask_same", 5, BYP ? 64'hF : 64'h0);
        idle(1'b0, 32'h0);
        lit("rd_addr", 0, 64'h100); lit("rd_count1", 3, 64'h1);
        idle(1'b1, 32'hDEADBEEF);
        lit("rd_resp", 1, 64'h1); lit("rd_rdata", 2, 64'hDEADBEEF);
        idle(1'b0, 32'h0);
        lit("rd_count0", 3, 64'h0);

        // Fill with writes, drop a fifth, drain in order.
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'(4 * i), 4'h0, 4'hF, 32'hA0 + 32'(i), 1'b0, 32'h0);
        cyc(1'b0, 32'h10, 4'h0, 4'hF, 32'hA4, 1'b0, 32'h0);
        lit("full_count", 3, 64'h4); lit("full_ready", 4, 64'h0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 32'h0);
            lit("drain_addr", 0, 64'(4 * i)); lit("drain_resp", 1, 64'h1);
        end
        idle(1'b0, 32'h0);
        lit("drain_count", 3, 64'h0);

        // Push and pop in the same cycle at count 2.
        cyc(1'b0, 32'h20, 4'hF, 4'h0, 32'h0, 1'b0, 32'h0);
        cyc(1'b0, 32'h24, 4'h0, 4'h3, 32'h77, 1'b0, 32'h0);
        cyc(1'b0, 32'h28, 4'h3, 4'hC, 32'h99, 1'b1, 32'h1234);
        lit("pp_count", 3, 64'h2); lit("pp_addr", 0, 64'h20); lit("pp_rdata", 2, 64'h1234);
        idle(1'b0, 32'h0);
        lit("pp_count_after", 3, 64'h2); lit("pp_head", 0, 64'h24); lit("pp_wmask", 6, 64'h3);
        idle(1'b1, 32'h1);
        idle(1'b1, 32'h2);
        lit("mixed_rmask", 5, 64'h3); lit("mixed_wmask", 6, 64'hC);
        idle(1'b0, 32'h0);

        // Response with nothing outstanding.
        idle(1'b1, 32'hCAFE);
        lit("orphan_resp", 1, 64'h0); lit("orphan_rdata", 2, 64'h0); lit("orphan_count", 3, 64'h0);

        // Fill/drain three times across pointer wrap.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) cyc(1'b0, 32'(4096 * (r + 1) + 4 * i), 4'hF, 4'h0, 32'h0, 1'b0, 32'h0);
            idle(1'b0, 32'h0);
            lit("wrap_full", 3, 64'h4);
            for (int i = 0; i < 4; i++) begin
                idle(1'b1, 32'(r * 16 + i));
                lit("wrap_addr", 0, 64'(4096 * (r + 1) + 4 * i));
            end
        end
        idle(1'b0, 32'h0);

        // Reset mid-operation with three queued.
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h200 + 32'(4 * i), 4'hF, 4'h0, 32'h0, 1'b0, 32'h0);
        idle(1'b0, 32'h0);
        lit("pre_rst_count", 3, 64'h3);
        cyc(1'b1, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        lit("mid_rst_count", 3, 64'h0);
        idle(1'b1, 32'hBAD);
        lit("post_rst_resp", 1, 64'h0); lit("post_rst_count", 3, 64'h0);

        // Empty-queue read with same-cycle response.
        cyc(1'b0, 32'h300, 4'hF, 4'h0, 32'h0, 1'b1, 32'h12345678);
        lit("byp_resp", 1, BYP ? 64'h1 : 64'h0);
        lit("byp_rmask", 5, BYP ? 64'hF : 64'h0);
        lit("byp_rdata", 2, BYP ? 64'h12345678 : 64'h0);
        idle(1'b0, 32'h0);
        lit("byp_count", 3, BYP ? 64'h0 : 64'h1);
        idle(1'b1, 32'h42);
        idle(1'b0, 32'h0);
        lit("end_count", 3, 64'h0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dserve_queue.md
DSERVE_QUEUE -- requirements
Module: dserve_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of buffered requests; legal values are powers of two, 2..16.
REQ-002 Parameter ADDR_W, default 32, meaning request address width.
REQ-003 Parameter DATA_W, default 32, meaning data width; mask width MW = DATA_W/8.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cpu_ufp_addr  in  ADDR_W  CPU request address.
REQ-007 cpu_ufp_rmask  in  MW  CPU read byte mask; a nonzero value means a read request.
REQ-008 cpu_ufp_wmask  in  MW  CPU write byte mask; a nonzero value means a write request.
REQ-009 cpu_ufp_wdata  in  DATA_W  CPU write data.
REQ-010 cpu_ready  out  1  queue can accept a request this cycle.
REQ-011 ufp_addr / ufp_rmask / ufp_wmask / ufp_wdata  out  ADDR_W/MW/MW/DATA_W  request presented to dcache.
REQ-012 ufp_resp  in  1  dcache completed the presented request.
REQ-013 ufp_rdata  in  DATA_W  dcache read data, valid with ufp_resp.
REQ-014 cpu_resp  out  1  completion of oldest outstanding request.
REQ-015 cpu_rdata  out  DATA_W  read data for that completion.
REQ-016 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 A request is valid when (cpu_ufp_rmask | cpu_ufp_wmask) != 0; all-zero masks are idle and never enqueued.
REQ-018 Requests with both masks nonzero are stored and forwarded unchanged; no checking.
REQ-019 cpu_ready = (count < DEPTH), computed from registered state only; a pop in the same cycle does not raise ready.
REQ-020 Push occurs when the request is valid and cpu_ready is 1; the entry is written at the tail and count increments.
REQ-021 A valid request presented with cpu_ready = 0 is dropped; the CPU must hold it until accepted.
REQ-022 When count > 0, ufp_* carry the head entry verbatim, with a 0-cycle path from the register.
REQ-023 When count = 0 and bypass is inactive, ufp_addr/wdata = 0 and ufp_rmask/wmask = 0.
REQ-024 Pop occurs when ufp_resp = 1 and count > 0; head advances and count decrements.
REQ-025 Simultaneous push and pop leaves count unchanged; both pointers advance.
REQ-026 Head and tail pointers wrap modulo DEPTH.
REQ-027 cpu_resp = ufp_resp AND (count > 0 OR bypass active); cpu_rdata = ufp_rdata combinationally; cpu_rdata = 0 when cpu_resp = 0.
REQ-028 A ufp_resp with nothing outstanding is ignored: no pop, cpu_resp = 0.
REQ-029 Completions return strictly in request order.
REQ-030 Head entry is stable while waiting; ufp_* must not change until ufp_resp.

Reset
REQ-031 On rst asserted: count = 0, pointers = 0, storage cleared to 0, and all outputs take their idle values: cpu_ready = 1, ufp_* = 0, cpu_resp = 0.
REQ-032 Reset mid-operation discards all queued and in-flight requests; a ufp_resp arriving after reset is ignored per REQ-028.

Configuration
REQ-033 Macro DSERVE_BYPASS_EN: when defined and count = 0, a valid CPU request drives ufp_* combinationally in the same cycle ("bypass active").
REQ-034 With bypass active and ufp_resp = 1 in that cycle, the request completes without being enqueued: cpu_resp = 1 and count stays 0.
REQ-035 With bypass active and ufp_resp = 0, the request is enqueued normally.
REQ-036 Without DSERVE_BYPASS_EN, bypass is never active; minimum CPU-to-dcache latency is 1 cycle.

Verification
REQ-037 Reset then single read addr=0x100, rmask=0xF: ufp_addr=0x100 next cycle; ufp_resp with rdata=0xDEADBEEF gives cpu_resp=1, cpu_rdata=0xDEADBEEF, count back to 0.
REQ-038 Push 4 writes (addr 0x0..0xC, DEPTH=4) with no resp: cpu_ready=0, count=4; a 5th request is dropped; 4 resps complete in order 0x0,0x4,0x8,0xC.
REQ-039 With count=2, push and resp in the same cycle: count stays 2 and the head advances to the 2nd entry.
REQ-040 Fill, drain, and refill 3 times: pointer wrap preserves FIFO order with no lost entries.
REQ-041 Assert rst with count=3; next ufp_resp gives cpu_resp=0 and count=0.
REQ-042 With DSERVE_BYPASS_EN and an empty queue, a read plus same-cycle ufp_resp gives cpu_resp=1 in that cycle and count=0; without the macro, ufp_rmask=0 that cycle.
